nixie_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit decimal (Nixie-style) display. It holds NUM_DIGITS BCD digits and steps through them one at a time. All digits share a single BCD-to-one-of-ten decoder. Each scan slot drives one anode strobe plus that digit's decimal cathode line, with a blanking gap between slots. It sits between the numeric datapath, which supplies new BCD values over a valid/ready load port, and the display drivers.

---
 rtl/nixie_scan_pkg.sv | 28 ++
 rtl/bcd10_dec.sv | 16 +
 rtl/nixie_scan_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nixie_scan_pkg.sv
// Shared types and helpers for the Nixie scan controller.
// Holds the FSM state enum, BCD/decimal widths and a highest-nonzero-digit helper.
package nixie_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  localparam int BCD_W = 4;
  localparam int DEC_W = 10;

  // Index of the highest nonzero BCD digit among the low n digits of d.
  // Returns 0 when every digit is zero, so digit 0 is always shown.
  function automatic logic [2:0] hi_nz(
    input logic [31:0] d,
    input int          n
  );
    logic [2:0] h;
    h = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n && d[i*BCD_W +: BCD_W] != '0) h = 3'(i);
    end
    return h;
  endfunction

endpackage

// File: rtl/bcd10_dec.sv
// Combinational BCD to one-of-ten decoder.
// Ports: bcd (4-bit code) -> dec (one-hot, bit k = decimal k), valid (0 for 10..15).
module bcd10_dec
  import nixie_scan_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [DEC_W-1:0] dec,
  output logic             valid
);

  always_comb begin
    valid = (bcd < 4'd10);
    dec   = valid ? (DEC_W'(1) << bcd) : '0;
  end

endmodule

// File: rtl/nixie_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit Nixie-style display.
// Ports: clk, rst_n (async low), enable, load_valid/load_data/load_ready,
//   err_clr in; anode (one-hot strobe), cathode (one-hot decimal),
//   frame_tick (commit pulse), err (sticky invalid-digit flag) out.
// Build option: define NIXIE_SCAN_LZB_EN for leading-zero blanking.
module nixie_scan_ctrl
  import nixie_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        load_valid,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
  output logic                        load_ready,
  input  logic                        err_clr,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic [DEC_W-1:0]            cathode,
  output logic                        frame_tick,
  output logic                        err
);

  localparam int DW = BCD_W * NUM_DIGITS;
  localparam int MX = (PRESCALE > BLANK_CYCLES)
                    ? PRESCALE : BLANK_CYCLES;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;
  localparam int IW = (NUM_DIGITS > 1)
                    ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] P_END = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] B_END = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] I_END = IW'(NUM_DIGITS - 1);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   disp, disp_n;
  logic [DW-1:0]   shadow, shadow_n;
  logic            pend, pend_n;
  logic            commit;
  logic            accept;

  logic [BCD_W-1:0]      digit;
  logic [DEC_W-1:0]      dec;
  logic                  dec_ok;
  logic                  show;
  logic                  drive;
  logic [NUM_DIGITS-1:0] anode_n;
  logic [DEC_W-1:0]      cathode_n;
  logic                  err_set;

  assign load_ready = !pend;
  assign accept     = load_valid && !pend;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    commit  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
      commit  = (state == IDLE) && pend;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = '0;
          commit  = pend;
        end
        BLANK: begin
          if (cnt == B_END) begin
            state_n = DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == P_END) begin
            state_n = BLANK;
            cnt_n   = '0;
            if (idx == I_END) begin
              idx_n  = '0;
              commit = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // A load accepted on a commit edge survives the pend clear.
  always_comb begin
    disp_n   = commit ? shadow : disp;
    shadow_n = accept ? load_data : shadow;
    pend_n   = accept ? 1'b1 : (commit ? 1'b0 : pend);
  end

  // Outputs are decoded from next-state so they register
  // on the same edge the FSM changes slot.
  assign digit = disp_n[idx_n*BCD_W +: BCD_W];

  bcd10_dec u_dec (
    .bcd   (digit),
    .dec   (dec),
    .valid (dec_ok)
  );

`ifdef NIXIE_SCAN_LZB_EN
  assign show = int'(idx_n) <=
                int'(hi_nz(32'(disp_n), NUM_DIGITS));
`else
  assign show = 1'b1;
`endif

  always_comb begin
    drive     = (state_n == DRIVE) && show;
    anode_n   = drive ? (NUM_DIGITS'(1) << idx_n) : '0;
    cathode_n = drive ? dec : '0;
    err_set   = drive && !dec_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      disp       <= '0;
      shadow     <= '0;
      pend       <= 1'b0;
      anode      <= '0;
      cathode    <= '0;
      frame_tick <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      disp       <= disp_n;
      shadow     <= shadow_n;
      pend       <= pend_n;
      anode      <= anode_n;
      cathode    <= cathode_n;
      frame_tick <= commit;
      err        <= err_set | (err & ~err_clr);
    end
  end

endmodule
